// File: rtl/mul_pipe_cdb_pkg.sv
// Shared types and default widths for the pipelined multiplier feeding the CDB.
// The flush feature of mul_pipe_cdb is enabled by defining MUL_FLUSH_EN.
package mul_pipe_cdb_pkg;

    localparam int DEF_XLEN    = 32;
    localparam int DEF_PRF_LEN = 6;
    localparam int DEF_ROB_LEN = 5;

    typedef enum logic [1:0] {
        MUL    = 2'd0,
        MULH   = 2'd1,
        MULHSU = 2'd2,
        MULHU  = 2'd3
    } mul_func_t;

    typedef struct packed {
        logic                   valid;
        logic [DEF_XLEN-1:0]    opa;
        logic [DEF_XLEN-1:0]    opb;
        mul_func_t              func;
        logic [DEF_PRF_LEN-1:0] prf_idx;
        logic [DEF_ROB_LEN-1:0] rob_idx;
        logic [DEF_XLEN-1:0]    pc;
    } MUL_PACKET;

    function automatic logic opa_signed(mul_func_t f);
        return f != MULHU;
    endfunction

    function automatic logic opb_signed(mul_func_t f);
        return (f == MUL) || (f == MULH);
    endfunction

endpackage

// File: rtl/mul_pipe_stage.sv
// One multiplier stage: folds BITS multiplier bits into the partial product
// and passes the tags along. Valid clears synchronously; data is unreset.
module mul_pipe_stage
    import mul_pipe_cdb_pkg::*;
#(
    parameter int XLEN    = DEF_XLEN,
    parameter int PRF_LEN = DEF_PRF_LEN,
    parameter int ROB_LEN = DEF_ROB_LEN,
    parameter int BITS    = 16
) (
    input  logic                 clock,
    input  logic                 clear_i,
    input  logic                 en_i,
    input  logic                 valid_i,
    input  mul_func_t            func_i,
    input  logic                 sign_i,
    input  logic [PRF_LEN-1:0]   prf_i,
    input  logic [ROB_LEN-1:0]   rob_i,
    input  logic [XLEN-1:0]      pc_i,
    input  logic [2*XLEN-1:0]    prod_i,
    input  logic [2*XLEN-1:0]    mcand_i,
    input  logic [2*XLEN-1:0]    mplier_i,
    output logic                 valid_o,
    output mul_func_t            func_o,
    output logic                 sign_o,
    output logic [PRF_LEN-1:0]   prf_o,
    output logic [ROB_LEN-1:0]   rob_o,
    output logic [XLEN-1:0]      pc_o,
    output logic [2*XLEN-1:0]    prod_o,
    output logic [2*XLEN-1:0]    mcand_o,
    output logic [2*XLEN-1:0]    mplier_o
);
    localparam int W = 2 * XLEN;
    localparam logic [W-1:0] MASK = {W{1'b1}} >> (W - BITS);

    logic               valid_q, valid_d;
    mul_func_t          func_q;
    logic               sign_q;
    logic [PRF_LEN-1:0] prf_q;
    logic [ROB_LEN-1:0] rob_q;
    logic [XLEN-1:0]    pc_q;
    logic [W-1:0]       prod_q, prod_d;
    logic [W-1:0]       mcand_q, mcand_d;
    logic [W-1:0]       mplier_q, mplier_d;

    always_comb begin
        valid_d  = valid_q;
        if (clear_i)
            valid_d = 1'b0;
        else if (en_i)
            valid_d = valid_i;
        prod_d   = prod_i + mcand_i * (mplier_i & MASK);
        mcand_d  = mcand_i << BITS;
        mplier_d = mplier_i >> BITS;
    end

    always_ff @(posedge clock) begin
        valid_q <= valid_d;
    end

    always_ff @(posedge clock) begin
        if (en_i) begin
            func_q   <= func_i;
            sign_q   <= sign_i;
            prf_q    <= prf_i;
            rob_q    <= rob_i;
            pc_q     <= pc_i;
            prod_q   <= prod_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end

    assign valid_o  = valid_q;
    assign func_o   = func_q;
    assign sign_o   = sign_q;
    assign prf_o    = prf_q;
    assign rob_o    = rob_q;
    assign pc_o     = pc_q;
    assign prod_o   = prod_q;
    assign mcand_o  = mcand_q;
    assign mplier_o = mplier_q;

endmodule

// File: rtl/mul_pipe_cdb.sv
// STAGES-deep sign/magnitude multiplier with a CDB output register.
// Define MUL_FLUSH_EN to add the flush port that squashes in-flight work.
module mul_pipe_cdb
    import mul_pipe_cdb_pkg::*;
#(
    parameter int XLEN    = DEF_XLEN,
    parameter int STAGES  = 4,
    parameter int PRF_LEN = DEF_PRF_LEN,
    parameter int ROB_LEN = DEF_ROB_LEN
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [XLEN-1:0]    in_opa,
    input  logic [XLEN-1:0]    in_opb,
    input  mul_func_t          in_func,
    input  logic [PRF_LEN-1:0] in_prf_idx,
    input  logic [ROB_LEN-1:0] in_rob_idx,
    input  logic [XLEN-1:0]    in_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_value,
    output logic [PRF_LEN-1:0] out_prf_idx,
    output logic [ROB_LEN-1:0] out_rob_idx,
    output logic [XLEN-1:0]    out_pc,
`ifdef MUL_FLUSH_EN
    input  logic               flush,
`endif
    output logic               busy
);
    localparam int W    = 2 * XLEN;
    localparam int BITS = W / STAGES;

    logic               adv, kill, a_neg, b_neg;
    logic [W-1:0]       a_mag, b_mag, full;
    logic [XLEN-1:0]    result;
    logic               unused_tail;

    logic [STAGES:0]    v, s;
    mul_func_t          f      [STAGES+1];
    logic [PRF_LEN-1:0] prf    [STAGES+1];
    logic [ROB_LEN-1:0] rob    [STAGES+1];
    logic [XLEN-1:0]    pc     [STAGES+1];
    logic [W-1:0]       prod   [STAGES+1];
    logic [W-1:0]       mcand  [STAGES+1];
    logic [W-1:0]       mplier [STAGES+1];

    logic               out_valid_q, out_valid_d;
    logic [XLEN-1:0]    out_value_q;
    logic [PRF_LEN-1:0] out_prf_q;
    logic [ROB_LEN-1:0] out_rob_q;
    logic [XLEN-1:0]    out_pc_q;

    assign adv = !out_valid_q || out_ready;
`ifdef MUL_FLUSH_EN
    assign kill     = reset || flush;
    assign in_ready = adv && !flush;
`else
    assign kill     = reset;
    assign in_ready = adv;
`endif

    // Operands become zero-extended magnitudes; the sign is reapplied at the end.
    always_comb begin
        a_neg = opa_signed(in_func) && in_opa[XLEN-1];
        b_neg = opb_signed(in_func) && in_opb[XLEN-1];
        a_mag = {{XLEN{1'b0}}, (a_neg ? -in_opa : in_opa)};
        b_mag = {{XLEN{1'b0}}, (b_neg ? -in_opb : in_opb)};
    end

    assign v[0]      = in_valid && in_ready;
    assign s[0]      = a_neg ^ b_neg;
    assign f[0]      = in_func;
    assign prf[0]    = in_prf_idx;
    assign rob[0]    = in_rob_idx;
    assign pc[0]     = in_pc;
    assign prod[0]   = '0;
    assign mcand[0]  = a_mag;
    assign mplier[0] = b_mag;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        mul_pipe_stage #(
            .XLEN    (XLEN),
            .PRF_LEN (PRF_LEN),
            .ROB_LEN (ROB_LEN),
            .BITS    (BITS)
        ) u_stage (
            .clock    (clock),
            .clear_i  (kill),
            .en_i     (adv),
            .valid_i  (v[i]),
            .func_i   (f[i]),
            .sign_i   (s[i]),
            .prf_i    (prf[i]),
            .rob_i    (rob[i]),
            .pc_i     (pc[i]),
            .prod_i   (prod[i]),
            .mcand_i  (mcand[i]),
            .mplier_i (mplier[i]),
            .valid_o  (v[i+1]),
            .func_o   (f[i+1]),
            .sign_o   (s[i+1]),
            .prf_o    (prf[i+1]),
            .rob_o    (rob[i+1]),
            .pc_o     (pc[i+1]),
            .prod_o   (prod[i+1]),
            .mcand_o  (mcand[i+1]),
            .mplier_o (mplier[i+1])
        );
    end

    assign unused_tail = ^{mcand[STAGES], mplier[STAGES]};

    always_comb begin
        full   = s[STAGES] ? -prod[STAGES] : prod[STAGES];
        result = (f[STAGES] == MUL) ? full[XLEN-1:0] : full[W-1:XLEN];
    end

    always_comb begin
        out_valid_d = out_valid_q;
        if (kill)
            out_valid_d = 1'b0;
        else if (adv)
            out_valid_d = v[STAGES];
    end

    always_ff @(posedge clock) begin
        out_valid_q <= out_valid_d;
    end

    always_ff @(posedge clock) begin
        if (adv && v[STAGES]) begin
            out_value_q <= result;
            out_prf_q   <= prf[STAGES];
            out_rob_q   <= rob[STAGES];
            out_pc_q    <= pc[STAGES];
        end
    end

    assign out_valid   = out_valid_q;
    assign out_value   = out_value_q;
    assign out_prf_idx = out_prf_q;
    assign out_rob_idx = out_rob_q;
    assign out_pc      = out_pc_q;
    assign busy        = (|v[STAGES:1]) || out_valid_q;

endmodule

// File: tb/tb_mul_pipe_cdb.sv
// Scoreboard bench for mul_pipe_cdb (XLEN=32, STAGES=4); driver pushes
// expected results, a negedge monitor pops and compares them.
module tb_mul_pipe_cdb;
    import mul_pipe_cdb_pkg::*;

    localparam int STAGES = 4;

    logic        clock, reset, in_valid, in_ready, out_valid, out_ready, busy;
    logic [31:0] in_opa, in_opb, in_pc, out_value, out_pc;
    mul_func_t   in_func;
    logic [5:0]  in_prf_idx, out_prf_idx;
    logic [4:0]  in_rob_idx, out_rob_idx;
`ifdef MUL_FLUSH_EN
    logic        flush;
`endif

    mul_pipe_cdb #(.XLEN(32), .STAGES(STAGES), .PRF_LEN(6), .ROB_LEN(5)) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_opa      (in_opa),
        .in_opb      (in_opb),
        .in_func     (in_func),
        .in_prf_idx  (in_prf_idx),
        .in_rob_idx  (in_rob_idx),
        .in_pc       (in_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_value   (out_value),
        .out_prf_idx (out_prf_idx),
        .out_rob_idx (out_rob_idx),
        .out_pc      (out_pc),
`ifdef MUL_FLUSH_EN
        .flush       (flush),
`endif
        .busy        (busy)
    );

    typedef struct {
        logic [31:0] value;
        logic [5:0]  prf;
        logic [4:0]  rob;
        logic [31:0] pc;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Reference: sign/zero-extend to 64 bits and multiply as plain integers.
    function automatic logic [31:0] model(mul_func_t fn, logic [31:0] a,
                                          logic [31:0] b);
        logic signed [63:0] ea, eb, p;
        ea = (fn == MULHU) ? $signed({32'b0, a}) : $signed({{32{a[31]}}, a});
        eb = (fn == MUL || fn == MULH) ? $signed({{32{b[31]}}, b})
                                       : $signed({32'b0, b});
        p  = ea * eb;
        return (fn == MUL) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom % 6)
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Called just after a posedge; returns just after the accepting posedge.
    task automatic issue(input mul_func_t fn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] e,
                         input bit lat);
        int n = 0;
        in_valid   = 1'b1;
        in_func    = fn;
        in_opa     = a;
        in_opb     = b;
        in_prf_idx = 6'($urandom);
        in_rob_idx = 5'($urandom);
        in_pc      = $urandom;
        forever begin
            @(negedge clock);
            if (in_ready) begin
                q.push_back('{value: e, prf: in_prf_idx, rob: in_rob_idx,
                              pc: in_pc, acc: cyc + 1, lat: lat});
                break;
            end
            n++;
            if (n > 200) begin
                check("accept_timeout", 64'(in_ready), 64'(1));
                break;
            end
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic rnd_issue(input bit lat);
        mul_func_t   fn;
        logic [31:0] a, b;
        fn = mul_func_t'($urandom_range(0, 3));
        a  = pick();
        b  = pick();
        issue(fn, a, b, model(fn, a, b), lat);
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || busy) && n < 500) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("drain_queue_empty", 64'(q.size()), 64'(0));
    endtask

    always @(negedge clock) begin
        if (!reset && out_valid) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL spurious_output: out_valid=1 value=0x%0h, required no output",
                         out_value);
            end else if (out_ready) begin
                mon_e = q.pop_front();
                check("out_value", 64'(out_value), 64'(mon_e.value));
                check("out_prf_idx", 64'(out_prf_idx), 64'(mon_e.prf));
                check("out_rob_idx", 64'(out_rob_idx), 64'(mon_e.rob));
                check("out_pc", 64'(out_pc), 64'(mon_e.pc));
                if (mon_e.lat)
                    check("latency", 64'(cyc - mon_e.acc), 64'(STAGES));
            end else begin
                check("stall_hold_value", 64'(out_value), 64'(q[0].value));
                check("stall_hold_prf", 64'(out_prf_idx), 64'(q[0].prf));
                check("stall_in_ready", 64'(in_ready), 64'(0));
            end
        end
    end

    initial begin
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_opa     = '0;
        in_opb     = '0;
        in_func    = MUL;
        in_prf_idx = '0;
        in_rob_idx = '0;
        in_pc      = '0;
        out_ready  = 1'b1;
`ifdef MUL_FLUSH_EN
        flush      = 1'b0;
`endif
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("reset_out_valid", 64'(out_valid), 64'(0));
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_in_ready", 64'(in_ready), 64'(1));
        @(posedge clock);
        #1;

        issue(MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b1);
        drain();
        issue(MULH,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        issue(MULHU,  32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 1'b1);
        issue(MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
        issue(MUL,    32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1);
        issue(MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b1);
        drain();

        for (int i = 0; i < 8; i++)
            rnd_issue(1'b1);
        drain();

        // Fill the pipe and the output register while the CDB withholds grant.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            rnd_issue(1'b0);
        fork
            rnd_issue(1'b0);
            begin
                repeat (5) @(negedge clock);
                check("full_busy", 64'(busy), 64'(1));
                @(posedge clock);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        for (int i = 0; i < 3; i++)
            rnd_issue(1'b0);
        reset = 1'b1;
        q.delete();
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("midreset_out_valid", 64'(out_valid), 64'(0));
        check("midreset_busy", 64'(busy), 64'(0));
        check("midreset_in_ready", 64'(in_ready), 64'(1));
        repeat (12) @(posedge clock);
        #1;

`ifdef MUL_FLUSH_EN
        in_valid = 1'b1;
        in_func  = MUL;
        in_opa   = 32'd5;
        in_opb   = 32'd6;
        flush    = 1'b1;
        @(negedge clock);
        check("flush_in_ready", 64'(in_ready), 64'(0));
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        @(negedge clock);
        check("flush_busy", 64'(busy), 64'(0));
        check("flush_out_valid", 64'(out_valid), 64'(0));
        @(posedge clock);
        #1;
        issue(MUL, 32'd9, 32'hFFFF_FFFE, 32'hFFFF_FFEE, 1'b1);
        drain();
`endif

        begin
            bit done = 1'b0;
            fork
                begin
                    for (int i = 0; i < 200; i++) begin
                        rnd_issue(1'b0);
                        repeat ($urandom % 2) begin
                            @(posedge clock);
                            #1;
                        end
                    end
                    done = 1'b1;
                end
                begin
                    while (!done) begin
                        @(posedge clock);
                        #1;
                        out_ready = ($urandom % 4) != 0;
                    end
                    out_ready = 1'b1;
                end
            join
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_pipe_cdb.md
MUL_PIPE_CDB -- requirements
Module: mul_pipe_cdb

Interface
REQ-001 SHALL have parameter XLEN, default 32: operand/result width.
REQ-002 SHALL have parameter STAGES, default 4: multiply pipeline depth; it SHALL divide 2*XLEN, and the legal range is 1..8.
REQ-003 SHALL have parameters PRF_LEN, default 6, and ROB_LEN, default 5: tag widths.
REQ-004 Port list: clock, input, 1, clock; reset, input, 1, reset (synchronous, active-high).
REQ-005 in_valid, input, 1: request present.
REQ-006 in_ready, output, 1: request accepted this cycle when in_valid is high.
REQ-007 in_opa, in_opb, input, XLEN: rs1/rs2 values.
REQ-008 in_func, input, 2: mul_func_t (MUL, MULH, MULHSU, MULHU).
REQ-009 in_prf_idx, input, PRF_LEN; in_rob_idx, input, ROB_LEN; in_pc, input, XLEN: tags carried with the request.
REQ-010 out_valid, output, 1: result held for the CDB.
REQ-011 out_ready, input, 1: CDB grant; the result retires on out_valid && out_ready.
REQ-012 out_value, output, XLEN; out_prf_idx, output, PRF_LEN; out_rob_idx, output, ROB_LEN; out_pc, output, XLEN: result and tags.
REQ-013 flush, input, 1: squash all in-flight work; present only with MUL_FLUSH_EN.
REQ-014 busy, output, 1: any stage or the output register is valid.

Function
REQ-015 SHALL be a STAGES-deep pipeline; each stage adds (2*XLEN/STAGES) multiplier bits times the shifted multiplicand into the accumulated partial product.
REQ-016 Each stage SHALL carry a valid bit, func, sign-of-result, prf/rob/pc tags, and the partial product.
REQ-017 The output register SHALL hold value, tags and out_valid.
REQ-018 Global advance: adv = !out_valid || out_ready; when adv=0 all stages and the output register SHALL hold.
REQ-019 in_ready SHALL equal adv; a request enters stage 0 only on in_valid && in_ready.
REQ-020 Latency: out_valid SHALL rise exactly STAGES cycles after acceptance when no stall occurs; throughput SHALL be 1/cycle under continuous out_ready.
REQ-021 A bubble (no accept while adv=1) SHALL propagate as valid=0 and SHALL NOT produce out_valid.
REQ-022 Operand signedness: MUL and MULH treat both operands as signed; MULHSU treats opa as signed and opb as unsigned; MULHU treats both as unsigned.
REQ-023 The datapath SHALL multiply 2*XLEN-bit magnitudes; result sign = signA XOR signB, with unsigned operands contributing sign 0.
REQ-024 Final negation SHALL be two's complement over the full 2*XLEN product, before slicing.
REQ-025 Result slicing: MUL returns product[XLEN-1:0]; MULH, MULHSU and MULHU return product[2*XLEN-1:XLEN].
REQ-026 Most-negative operands (0x80000000) SHALL yield exact results; magnitude extension SHALL be zero-filled to 2*XLEN.
REQ-027 out_valid && out_ready together with a new final-stage valid in the same cycle SHALL load the new result, with no bubble inserted.
REQ-028 Results SHALL leave in acceptance order; there SHALL be no reordering.

Reset
REQ-029 On reset: all stage valid bits = 0, out_valid = 0, busy = 0, and in_ready = 1 in the following cycle.
REQ-030 Data and tag registers SHALL be unreset; out_value is don't-care while out_valid = 0.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight requests, with no output afterward.

Configuration
REQ-032 The macro MUL_FLUSH_EN SHALL control the flush feature.
REQ-033 With MUL_FLUSH_EN defined, flush=1 SHALL clear all stage valids and out_valid at the next edge, and in_ready SHALL be forced to 0 that cycle (the simultaneous request is dropped).
REQ-034 Without MUL_FLUSH_EN, there SHALL be no flush port and no flush logic.

Structure
REQ-035 mul_func_t, MUL_PACKET (the input bundle) and XLEN/PRF_LEN/ROB_LEN defaults SHALL live in the shared package.
REQ-036 There SHALL be one sub-module, mul_pipe_stage: a single stage with enable, valid, partial product, shifted operands and tag pass-through, instantiated STAGES times by generate.

Verification (XLEN=32, STAGES=4)
REQ-037 MUL 7 x -3 -> out_value 0xFFFFFFEB, exactly 4 cycles after accept.
REQ-038 MULH 0x80000000 x 0xFFFFFFFF -> 0x00000000; MULHU of the same operands -> 0x7FFFFFFF; MULHSU of the same operands -> 0x80000000.
REQ-039 Issue 8 back-to-back requests with out_ready=1 -> 8 consecutive out_valid cycles, in order, tags matching.
REQ-040 Hold out_ready=0 for 5 cycles with the pipe full -> in_ready=0, all values held; on release, results drain with none lost or duplicated.
REQ-041 Assert reset with 3 requests in flight -> out_valid=0 and busy=0 the next cycle, and no result ever appears.
REQ-042 With MUL_FLUSH_EN, flush together with in_valid -> request dropped, pipe empty the next cycle, and the next accepted request returns after 4 cycles.
